// File: rtl/threefish_pkg.sv
// Shared definitions for the Threefish-512 host loader: default sizes, field tags,
// loader state encoding and the core round count.
package threefish_pkg;

    localparam int WW_DEF = 64;
    localparam int NW_DEF = 8;
    localparam int TW_DEF = 2;

    localparam logic [1:0] TAG_KEY   = 2'b00;
    localparam logic [1:0] TAG_TWEAK = 2'b01;
    localparam logic [1:0] TAG_BLOCK = 2'b10;
    localparam logic [1:0] TAG_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_UNLOAD
    } state_e;

    localparam int CORE_ROUNDS = 73;

endpackage

// File: rtl/threefish_word_packer.sv
// Per-field word assembler: writes word cnt into its slot, saturating count,
// full flag and a look-ahead full flag that includes this cycle's write.
module threefish_word_packer #(
    parameter int WW = 64,
    parameter int N  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [WW-1:0]   wr_data,
    input  logic            clr,
    output logic [N*WW-1:0] field,
    output logic            full,
    output logic            full_next
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N*WW-1:0] field_q, field_d;

    always_comb begin
        cnt_d   = cnt_q;
        field_d = field_q;
        if (clr) begin
            cnt_d = '0;
        end else if (wr_en && !full) begin
            for (int i = 0; i < N; i++) begin
                if (cnt_q == CW'(i)) field_d[i*WW +: WW] = wr_data;
            end
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign full      = (cnt_q == CW'(N));
    assign full_next = (cnt_d == CW'(N));
    assign field     = field_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            field_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            field_q <= field_d;
        end
    end

endmodule

// File: rtl/threefish_host_loader.sv
// Host-side initiator for the Threefish-512 core: assembles key/tweak/block, fires the
// core strobes, waits for the run, streams the result. THREEFISH_LOADER_KEY_REUSE_EN keeps key/tweak.
module threefish_host_loader
    import threefish_pkg::*;
#(
    parameter int WW = WW_DEF,
    parameter int NW = NW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic             inClk,
    input  logic             inRst,
    input  logic [WW-1:0]    inData,
    input  logic [1:0]       inTag,
    input  logic             inValid,
    output logic             outReady,
    output logic [WW-1:0]    outData,
    output logic             outValid,
    input  logic             inReady,
    output logic             outLast,
    output logic [NW*WW-1:0] outKey,
    output logic [TW*WW-1:0] outTweak,
    output logic [NW*WW-1:0] outBlock,
    output logic             outKeyWr,
    output logic             outTweakWr,
    output logic             outBlockWr,
    input  logic             inCoreBusy,
    input  logic [NW*WW-1:0] inCoreBlock,
    output logic             outBusy,
    output logic             outTagErr
);

    localparam int IW = $clog2(NW);

    state_e            state_q, state_d;
    logic              seen_busy_q, seen_busy_d;
    logic [IW-1:0]     idx_q, idx_d, nidx;
    logic [NW*WW-1:0]  res_q, res_d;
    logic [WW-1:0]     data_q, data_d;
    logic              valid_q, valid_d, last_q, last_d, tag_err_q, tag_err_d;
    logic [2:0]        full, full_next, wr;
    logic              ready, accept, unload_done, clr_kt;

    always_comb begin
        ready = 1'b0;
        if (state_q == ST_LOAD) begin
            case (inTag)
                TAG_KEY:   ready = !full[0];
                TAG_TWEAK: ready = !full[1];
                TAG_BLOCK: ready = !full[2];
                default:   ready = 1'b1;
            endcase
        end
    end

    assign accept      = inValid && ready;
    assign wr[0]       = accept && (inTag == TAG_KEY);
    assign wr[1]       = accept && (inTag == TAG_TWEAK);
    assign wr[2]       = accept && (inTag == TAG_BLOCK);
    assign unload_done = (state_q == ST_UNLOAD) && valid_q && inReady && (idx_q == IW'(NW - 1));

`ifdef THREEFISH_LOADER_KEY_REUSE_EN
    // Key and tweak stay loaded across blocks; only a reset empties them.
    assign clr_kt = 1'b0;
`else
    assign clr_kt = unload_done;
`endif

    threefish_word_packer #(.WW(WW), .N(NW)) u_key (
        .clk(inClk), .rst(inRst), .wr_en(wr[0]), .wr_data(inData), .clr(clr_kt),
        .field(outKey), .full(full[0]), .full_next(full_next[0])
    );

    threefish_word_packer #(.WW(WW), .N(TW)) u_tweak (
        .clk(inClk), .rst(inRst), .wr_en(wr[1]), .wr_data(inData), .clr(clr_kt),
        .field(outTweak), .full(full[1]), .full_next(full_next[1])
    );

    threefish_word_packer #(.WW(WW), .N(NW)) u_block (
        .clk(inClk), .rst(inRst), .wr_en(wr[2]), .wr_data(inData), .clr(unload_done),
        .field(outBlock), .full(full[2]), .full_next(full_next[2])
    );

    assign nidx = idx_q + IW'(1);

    always_comb begin
        state_d     = state_q;
        seen_busy_d = seen_busy_q;
        idx_d       = idx_q;
        res_d       = res_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        tag_err_d   = accept && (inTag == TAG_RSVD);
        case (state_q)
            ST_LOAD: begin
                // Never strobe into a busy core, even after a loader-only reset.
                if ((&full_next) && !inCoreBusy) state_d = ST_START;
            end
            ST_START: begin
                seen_busy_d = 1'b0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (inCoreBusy) seen_busy_d = 1'b1;
                if (seen_busy_q && !inCoreBusy) begin
                    res_d   = inCoreBlock;
                    data_d  = inCoreBlock[WW-1:0];
                    valid_d = 1'b1;
                    last_d  = (NW == 1);
                    idx_d   = '0;
                    state_d = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (valid_q && inReady) begin
                    if (idx_q == IW'(NW - 1)) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_LOAD;
                    end else begin
                        idx_d = nidx;
                        for (int i = 0; i < NW; i++) begin
                            if (nidx == IW'(i)) data_d = res_q[i*WW +: WW];
                        end
                        last_d = (nidx == IW'(NW - 1));
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            state_q     <= ST_LOAD;
            seen_busy_q <= 1'b0;
            idx_q       <= '0;
            res_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            tag_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seen_busy_q <= seen_busy_d;
            idx_q       <= idx_d;
            res_q       <= res_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            tag_err_q   <= tag_err_d;
        end
    end

    assign outReady   = ready;
    assign outData    = data_q;
    assign outValid   = valid_q;
    assign outLast    = last_q;
    assign outKeyWr   = (state_q == ST_START);
    assign outTweakWr = (state_q == ST_START);
    assign outBlockWr = (state_q == ST_START);
    assign outBusy    = (state_q != ST_LOAD);
    assign outTagErr  = tag_err_q;

endmodule

// File: tb/tb_threefish_host_loader.sv
// Bench for threefish_host_loader: core model returning block+1 per word, field model
// driven by what the bench sends, directed and randomized block runs.
module tb_threefish_host_loader;
    import threefish_pkg::*;

    localparam int WW = 64;
    localparam int NW = 8;
    localparam int TW = 2;
    localparam int FB = NW * WW + 1;

    logic             inClk = 1'b0;
    logic             inRst, inValid, inReady;
    logic [WW-1:0]    inData;
    logic [1:0]       inTag;
    logic             outReady, outValid, outLast, outBusy, outTagErr;
    logic [WW-1:0]    outData;
    logic [NW*WW-1:0] outKey, outBlock;
    logic [TW*WW-1:0] outTweak;
    logic             outKeyWr, outTweakWr, outBlockWr;

    logic             core_busy = 1'b0;
    int               core_left = 0;
    logic [NW*WW-1:0] core_res  = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int               strobe_cnt = 0, strobe_cyc = 0, valid_cyc = 0, hs_cnt = 0, last_hs_cyc = 0;
    logic [NW*WW-1:0] cap_key, cap_blk;
    logic [TW*WW-1:0] cap_tw;
    logic [WW:0]      got[$];

    logic [WW-1:0]    m_f [0:2][0:NW-1];
    int               m_cnt [0:2];

    threefish_host_loader #(.WW(WW), .NW(NW), .TW(TW)) dut (
        .inClk(inClk), .inRst(inRst), .inData(inData), .inTag(inTag), .inValid(inValid),
        .outReady(outReady), .outData(outData), .outValid(outValid), .inReady(inReady),
        .outLast(outLast), .outKey(outKey), .outTweak(outTweak), .outBlock(outBlock),
        .outKeyWr(outKeyWr), .outTweakWr(outTweakWr), .outBlockWr(outBlockWr),
        .inCoreBusy(core_busy), .inCoreBlock(core_res), .outBusy(outBusy), .outTagErr(outTagErr)
    );

    always #5 inClk = ~inClk;

    always @(posedge inClk) cyc <= cyc + 1;

    // Core model: busy from the cycle after the strobe for CORE_ROUNDS cycles, result = block + 1 per word.
    always @(posedge inClk) begin
        if (outKeyWr) begin
            core_busy <= 1'b1;
            core_left <= CORE_ROUNDS;
            for (int i = 0; i < NW; i++) core_res[i*WW +: WW] <= outBlock[i*WW +: WW] + 64'd1;
        end else if (core_left > 0) begin
            core_left <= core_left - 1;
            if (core_left == 1) core_busy <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [FB-1:0] obs, input logic [FB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cap_of(input int t);
        return (t == 1) ? TW : NW;
    endfunction

    function automatic logic [NW*WW-1:0] mfield(input int t);
        logic [NW*WW-1:0] r = '0;
        for (int i = 0; i < cap_of(t); i++) r[i*WW +: WW] = m_f[t][i];
        return r;
    endfunction

    function automatic logic [WW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic send_word(input logic [1:0] tag, input logic [WW-1:0] d, output int acc);
        bit ok = 1'b0;
        int g = 0;
        acc = 0;
        @(posedge inClk); #1;
        inValid = 1'b1; inTag = tag; inData = d;
        while (!ok && g < 3000) begin
            @(negedge inClk);
            ok = outReady; acc = cyc; g++;
            @(posedge inClk); #1;
        end
        inValid = 1'b0;
        chk("word_accepted", FB'(ok), FB'(1));
        if (ok && tag != TAG_RSVD) begin
            m_f[tag][m_cnt[tag]] = d;
            m_cnt[tag]++;
        end
    endtask

    // Sends every word still missing from the three fields, in shuffled order.
    task automatic load_rest();
        logic [1:0] q[$];
        logic [1:0] tmp;
        int acc, j;
        for (int t = 0; t < 3; t++)
            for (int i = m_cnt[t]; i < cap_of(t); i++) q.push_back(2'(t));
        for (int i = q.size() - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = q[i]; q[i] = q[j]; q[j] = tmp;
        end
        foreach (q[k]) send_word(q[k], rnd64(), acc);
    endtask

    task automatic wait_strobe(input int prev);
        int g = 0;
        while (strobe_cnt == prev && g < 500) begin
            @(posedge inClk); #1;
            g++;
        end
        chk("strobe_seen", FB'(strobe_cnt), FB'(prev + 1));
    endtask

    task automatic unload(input bit rnd);
        int base = hs_cnt;
        int g = 0;
        int st = 0;
        got.delete();
        while (hs_cnt - base < NW && g < 3000) begin
            @(posedge inClk); #1;
            g++;
            if (hs_cnt - base == 3 && outValid && st < 5) begin
                inReady = 1'b0; st++;
            end else begin
                inReady = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            end
        end
        inReady = 1'b1;
        chk("unload_count", FB'(hs_cnt - base), FB'(NW));
        chk("word3_stall_len", FB'(st), FB'(5));
    endtask

    task automatic check_out(input logic [NW*WW-1:0] blk);
        for (int i = 0; i < NW; i++) begin
            if (i < got.size())
                chk($sformatf("out_word%0d", i), FB'(got[i]),
                    FB'({(i == NW - 1), blk[i*WW +: WW] + 64'd1}));
            else
                chk($sformatf("out_word%0d_missing", i), FB'(got.size()), FB'(NW));
        end
    endtask

    logic [NW*WW-1:0] k_exp, b_exp, blk;
    logic [TW*WW-1:0] t_exp;
    logic [WW-1:0]    xw;
    int               acc, s0, s1, s2, s3;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        inRst = 1'b1; inValid = 1'b0; inTag = 2'b00; inData = '0; inReady = 1'b1;
        for (int t = 0; t < 3; t++) begin
            m_cnt[t] = 0;
            for (int i = 0; i < NW; i++) m_f[t][i] = '0;
        end

        // Monitors: strobes, result handshakes, stall stability.
        fork
            begin
                bit prev_strobe = 1'b0, prev_stall = 1'b0, prev_valid = 1'b0, prev_last = 1'b0;
                logic [WW-1:0] prev_data = '0;
                forever begin
                    @(negedge inClk);
                    if (outKeyWr || outTweakWr || outBlockWr) begin
                        chk("strobes_together", FB'({outKeyWr, outTweakWr, outBlockWr}), FB'(3'b111));
                        chk("strobe_core_idle", FB'(core_busy), FB'(0));
                        chk("strobe_one_cycle", FB'(prev_strobe), FB'(0));
                        strobe_cnt++; strobe_cyc = cyc;
                        cap_key = outKey; cap_tw = outTweak; cap_blk = outBlock;
                    end
                    prev_strobe = outKeyWr;
                    if (prev_stall)
                        chk("hold_stalled", FB'({outValid, outLast, outData}), FB'({1'b1, prev_last, prev_data}));
                    prev_stall = outValid && !inReady;
                    prev_last = outLast; prev_data = outData;
                    if (outValid && !prev_valid) valid_cyc = cyc;
                    prev_valid = outValid;
                    if (outValid && inReady) begin
                        got.push_back({outLast, outData});
                        hs_cnt++; last_hs_cyc = cyc;
                        if (outLast) begin
                            m_cnt[2] = 0;
`ifndef THREEFISH_LOADER_KEY_REUSE_EN
                            m_cnt[0] = 0; m_cnt[1] = 0;
`endif
                        end
                    end
                end
            end
        join_none

        repeat (2) @(posedge inClk);
        #1;
        chk("rst_ready", FB'(outReady), FB'(1));
        chk("rst_busy", FB'(outBusy), FB'(0));
        chk("rst_valid_last", FB'({outValid, outLast}), FB'(0));
        chk("rst_strobes", FB'({outKeyWr, outTweakWr, outBlockWr}), FB'(0));
        chk("rst_tagerr", FB'(outTagErr), FB'(0));
        chk("rst_key", FB'(outKey), FB'(0));
        chk("rst_tweak", FB'(outTweak), FB'(0));
        chk("rst_block", FB'(outBlock), FB'(0));
        chk("rst_data", FB'(outData), FB'(0));
        inRst = 1'b0;

        // Directed interleaved load with a reserved-tag word in the middle.
        for (int i = 0; i < NW; i++) begin
            k_exp[i*WW +: WW] = 64'(i);
            b_exp[i*WW +: WW] = 64'(32 + i);
        end
        for (int i = 0; i < TW; i++) t_exp[i*WW +: WW] = 64'(16 + i);
        s0 = strobe_cnt;
        for (int i = 0; i < NW; i++) begin
            send_word(TAG_KEY, 64'(i), acc);
            if (i < TW) send_word(TAG_TWEAK, 64'(16 + i), acc);
            send_word(TAG_BLOCK, 64'(32 + i), acc);
            if (i == 3) begin
                send_word(TAG_RSVD, 64'hDEAD, acc);
                chk("tagerr_pulse", FB'(outTagErr), FB'(1));
                chk("tagerr_key", FB'(outKey), FB'(mfield(0)));
                chk("tagerr_tweak", FB'(outTweak), FB'(mfield(1)));
                chk("tagerr_block", FB'(outBlock), FB'(mfield(2)));
                @(posedge inClk); #1;
                chk("tagerr_clear", FB'(outTagErr), FB'(0));
            end
        end
        wait_strobe(s0);
        chk("t1_key", FB'(cap_key), FB'(k_exp));
        chk("t1_tweak", FB'(cap_tw), FB'(t_exp));
        chk("t1_block", FB'(cap_blk), FB'(b_exp));

        // A ninth block word waits out the run and unload, then becomes word 0 of the next block.
        xw = 64'h9999_0000_0000_0009;
        fork
            send_word(TAG_BLOCK, xw, acc);
            unload(1'b0);
        join
        chk("t1_latency", FB'(valid_cyc - strobe_cyc), FB'(CORE_ROUNDS + 2));
        check_out(b_exp);
        chk("t1_one_strobe", FB'(strobe_cnt), FB'(s0 + 1));
        chk("ninth_after_unload", FB'(acc > last_hs_cyc), FB'(1));
        chk("ninth_is_word0", FB'(outBlock[WW-1:0]), FB'(xw));
        chk("ninth_idle", FB'(outBusy), FB'(0));

        // Randomized block with random output backpressure.
        s1 = strobe_cnt;
`ifdef THREEFISH_LOADER_KEY_REUSE_EN
        @(posedge inClk); #1;
        inValid = 1'b1; inTag = TAG_KEY; inData = rnd64();
        repeat (3) begin
            @(negedge inClk);
            chk("reuse_key_stall", FB'({outReady, outBusy}), FB'(0));
        end
        @(posedge inClk); #1;
        inValid = 1'b0;
`endif
        while (m_cnt[2] < NW) send_word(TAG_BLOCK, rnd64(), acc);
`ifndef THREEFISH_LOADER_KEY_REUSE_EN
        @(posedge inClk); #1;
        inValid = 1'b1; inTag = TAG_BLOCK; inData = rnd64();
        repeat (3) begin
            @(negedge inClk);
            chk("block_full_stall", FB'({outReady, outBusy}), FB'(0));
        end
        @(posedge inClk); #1;
        inValid = 1'b0;
        load_rest();
`endif
        wait_strobe(s1);
        chk("t2_key", FB'(cap_key), FB'(mfield(0)));
        chk("t2_tweak", FB'(cap_tw), FB'(mfield(1)));
        chk("t2_block", FB'(cap_blk), FB'(mfield(2)));
`ifdef THREEFISH_LOADER_KEY_REUSE_EN
        chk("reuse_first_key", FB'(cap_key), FB'(k_exp));
        chk("reuse_first_tweak", FB'(cap_tw), FB'(t_exp));
`endif
        blk = mfield(2);
        unload(1'b1);
        check_out(blk);
        chk("t2_one_strobe", FB'(strobe_cnt), FB'(s1 + 1));

        // Loader reset while the core is mid-run, then a full reload.
        s2 = strobe_cnt;
        load_rest();
        wait_strobe(s2);
        repeat (10) @(posedge inClk);
        #1;
        chk("wait_busy", FB'({outBusy, outValid}), FB'(2'b10));
        inRst = 1'b1;
        @(posedge inClk); #1;
        inRst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            m_cnt[t] = 0;
            for (int i = 0; i < NW; i++) m_f[t][i] = '0;
        end
        chk("midrst_idle", FB'({outBusy, outReady}), FB'(2'b01));
        chk("midrst_key", FB'(outKey), FB'(0));
        s3 = strobe_cnt;
        load_rest();
        chk("midrst_held", FB'(strobe_cnt), FB'(s3));
        wait_strobe(s3);
        chk("t3_key", FB'(cap_key), FB'(mfield(0)));
        chk("t3_tweak", FB'(cap_tw), FB'(mfield(1)));
        chk("t3_block", FB'(cap_blk), FB'(mfield(2)));
        blk = mfield(2);
        unload(1'b1);
        check_out(blk);
        chk("t3_one_strobe", FB'(strobe_cnt), FB'(s3 + 1));

        repeat (3) @(posedge inClk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/threefish_host_loader.md
# threefish_host_loader

Host-side initiator for the Threefish-512 block core. It accepts 64-bit tagged words from a valid/ready input stream and assembles them into key, tweak and plaintext registers. It then fires the core's key/tweak/block write strobes together in one cycle, waits for the core's round run to finish, and streams the 512-bit result back out as eight 64-bit words. It sits between the system bus adapter and the block core and is the only agent driving the core's write strobes.

## Interface
Parameters:
- WW, 64, word width in bits
- NW, 8, words per key and per block (Threefish-512)
- TW, 2, words per tweak

Ports:
- inClk  in  1  clock
- inRst  in  1  reset; one clock, synchronous, active-high
- inData  in  WW  input word
- inTag  in  2  field select: 00 key, 01 tweak, 10 block, 11 reserved
- inValid  in  1  input word valid
- outReady  out  1  input word accepted when inValid && outReady
- outData  out  WW  result word
- outValid  out  1  result word valid
- inReady  in  1  downstream accepts result word
- outLast  out  1  high with result word NW-1
- outKey  out  NW*WW  assembled key to core
- outTweak  out  TW*WW  assembled tweak to core
- outBlock  out  NW*WW  assembled plaintext to core
- outKeyWr, outTweakWr, outBlockWr  out  1 each  core write strobes; always pulsed together
- inCoreBusy  in  1  core busy
- inCoreBlock  in  NW*WW  core result register
- outBusy  out  1  high whenever state is not LOAD
- outTagErr  out  1  one-cycle pulse when a tag-11 word is accepted

## Operation
- States: LOAD, START, WAIT, UNLOAD.
- LOAD:
  - outReady = !fieldFull(inTag); tag 11 is always ready.
  - An accepted word goes to field word index cnt[tag]; word 0 occupies bits [WW-1:0]. Then cnt[tag]++.
  - A word for a full field stalls (outReady low); it is not dropped.
  - Tag 11 word: discarded, outTagErr pulses.
  - Exit to START when all three fields are full and inCoreBusy==0. This includes the case where the last word completes in that same cycle.
- START:
  - One cycle. All three strobes are high and outKey/outTweak/outBlock are stable.
  - Clear seenBusy; go to WAIT.
- WAIT:
  - Set seenBusy when inCoreBusy==1.
  - When seenBusy && inCoreBusy==0: capture inCoreBlock into the output register, go to UNLOAD.
- UNLOAD:
  - Present result words 0..NW-1 in order; advance on outValid && inReady.
  - outLast is high on word NW-1.
  - After the handshake on word NW-1: clear the field counters (see Configuration) and go to LOAD.
- Counters are $clog2(NW+1) bits. A counter saturates at full and never wraps.
- Core isolation: inRst does not reset the core. After a mid-run loader reset, LOAD still gates START on inCoreBusy==0, so the loader never issues strobes into a busy core.

## Timing
- Reset values:
  - State LOAD.
  - All counters 0; seenBusy 0.
  - outKey/outTweak/outBlock/outData = 0.
  - outValid, outLast, all strobes, outTagErr, outBusy = 0.
  - outReady = 1.
- Last input word accepted at edge E: strobes high during cycle E+1. Core busy rises at E+2.
- Core run is 73 busy cycles. The result is captured on the first busy-low cycle. outValid rises the next cycle.
- outData/outValid/outLast are registered and hold stable while outValid && !inReady.
- Strobes are high for exactly one cycle per block. They are never high while inCoreBusy==1.

## Configuration
- THREEFISH_LOADER_KEY_REUSE_EN defined:
  - After UNLOAD, only the block counter is cleared. Key and tweak stay full and are retained.
  - The next block needs only NW block words. All three strobes still pulse, with the retained key and tweak values.
  - Tag 00/01 words in LOAD stall until reset.
- Not defined: all three counters are cleared after UNLOAD, so every block requires a full key, tweak and block reload.

## Structure
- threefish_pkg holds:
  - WW/NW/TW defaults
  - tag encodings TAG_KEY, TAG_TWEAK, TAG_BLOCK, TAG_RSVD
  - state enum
  - CORE_ROUNDS = 73 (used by the bench)
- One sub-module, threefish_word_packer. It is a per-field word assembler with write index, saturating count and full flag. It is instantiated three times, for key, tweak and block.

## Test plan
- Load key 0x00..07, tweak 0x10..11, block 0x20..27 in interleaved order:
  - one strobe cycle, with fields matching exactly
  - with a core model returning block+1 per word: output 0x21..0x28, outLast on the eighth word
- Ninth block word while the block field is full -> outReady low for tag 10. The word is taken after UNLOAD completes, as block word 0 of the next block.
- Tag 11 word 0xDEAD in LOAD -> outTagErr one cycle, no field or counter change.
- inRst asserted in WAIT while the core model is busy, then a full reload -> strobes held low until inCoreBusy==0, then exactly one pulse.
- inReady held low for 5 cycles on word 3 -> outData stable at word 3, no word skipped or repeated.
- With THREEFISH_LOADER_KEY_REUSE_EN: second block of eight words only -> strobes fire carrying the first key and tweak.
